// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: writes a seeded address pattern into an R x C x N array, reads it back and counts mismatches.
// Optional first-failure capture ports are enabled with `define MEMBIST_FAIL_CAPTURE_EN.
module mem_bist_ctrl #(
   parameter int unsigned R = 4,
   parameter int unsigned C = 4,
   parameter int unsigned N = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [N-1:0]               seed,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [$clog2(R*C+1)-1:0]   err_cnt,
   output logic                       req,
   output logic                       rw,
   output logic                       cs,
   output logic [N-1:0]               Qi,
   output logic [$clog2(R)-1:0]       ar,
   output logic [$clog2(C)-1:0]       ac,
`ifdef MEMBIST_FAIL_CAPTURE_EN
   output logic [$clog2(R)-1:0]       fail_ar,
   output logic [$clog2(C)-1:0]       fail_ac,
   output logic [N-1:0]               fail_data,
`endif
   input  logic [N-1:0]               Qa,
   input  logic                       valid
);

   localparam int unsigned RW    = $clog2(R);
   localparam int unsigned CW    = $clog2(C);
   localparam int unsigned EW    = $clog2(R*C+1);
   localparam int unsigned CELLS = R*C;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [RW-1:0]   ar_q, ar_d;
   logic [CW-1:0]   ac_q, ac_d;
   logic [N-1:0]    seed_q, seed_d;
   logic [EW-1:0]   err_q, err_d;
   logic [N-1:0]    qi_q, qi_d;
   logic            req_q, req_d;
   logic            rw_q, rw_d;
   logic            cs_q, cs_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic            last_col_c;
   logic            last_cell_c;
   logic [RW-1:0]   nxt_ar_c;
   logic [CW-1:0]   nxt_ac_c;
   logic            mismatch_c;

`ifdef MEMBIST_FAIL_CAPTURE_EN
   logic            fail_seen_q, fail_seen_d;
   logic [RW-1:0]   fail_ar_q, fail_ar_d;
   logic [CW-1:0]   fail_ac_q, fail_ac_d;
   logic [N-1:0]    fail_data_q, fail_data_d;
`endif

   // Pattern word for a cell: seed plus linear row-major index, truncated to N bits.
   function automatic logic [N-1:0] exp_word(input logic [N-1:0] s,
                                             input logic [RW-1:0] r,
                                             input logic [CW-1:0] c);
      return N'(32'(s) + 32'(r) * C + 32'(c));
   endfunction

   // Row-major address stepping, column fastest.
   always_comb begin
      last_col_c  = (ac_q == CW'(C-1));
      last_cell_c = last_col_c && (ar_q == RW'(R-1));
      nxt_ac_c    = last_col_c ? '0 : ac_q + CW'(1);
      nxt_ar_c    = last_col_c ? ar_q + RW'(1) : ar_q;
      mismatch_c  = !valid || (Qa != exp_word(seed_q, ar_q, ac_q));
   end

   always_comb begin
      state_d = state_q;
      ar_d    = ar_q;
      ac_d    = ac_q;
      seed_d  = seed_q;
      err_d   = err_q;
      qi_d    = '0;
      req_d   = 1'b0;
      rw_d    = 1'b0;
      cs_d    = 1'b0;
`ifdef MEMBIST_FAIL_CAPTURE_EN
      fail_seen_d = fail_seen_q;
      fail_ar_d   = fail_ar_q;
      fail_ac_d   = fail_ac_q;
      fail_data_d = fail_data_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            ar_d = '0;
            ac_d = '0;
            if (start) begin
               seed_d  = seed;
               err_d   = '0;
               state_d = S_WR;
               cs_d    = 1'b1;
               req_d   = 1'b1;
               qi_d    = exp_word(seed, '0, '0);
`ifdef MEMBIST_FAIL_CAPTURE_EN
               fail_seen_d = 1'b0;
               fail_ar_d   = '0;
               fail_ac_d   = '0;
               fail_data_d = '0;
`endif
            end
         end
         S_WR: begin
            cs_d  = 1'b1;
            req_d = 1'b1;
            if (last_cell_c) begin
               state_d = S_RD;
               ar_d    = '0;
               ac_d    = '0;
               rw_d    = 1'b1;
            end else begin
               ar_d = nxt_ar_c;
               ac_d = nxt_ac_c;
               qi_d = exp_word(seed_q, nxt_ar_c, nxt_ac_c);
            end
         end
         S_RD: begin
            state_d = S_CMP;
            cs_d    = 1'b1;
         end
         S_CMP: begin
            if (mismatch_c && (err_q != EW'(CELLS))) begin
               err_d = err_q + EW'(1);
            end
`ifdef MEMBIST_FAIL_CAPTURE_EN
            if (mismatch_c && !fail_seen_q) begin
               fail_seen_d = 1'b1;
               fail_ar_d   = ar_q;
               fail_ac_d   = ac_q;
               fail_data_d = Qa;
            end
`endif
            if (last_cell_c) begin
               state_d = S_DONE;
               ar_d    = '0;
               ac_d    = '0;
            end else begin
               state_d = S_RD;
               ar_d    = nxt_ar_c;
               ac_d    = nxt_ac_c;
               cs_d    = 1'b1;
               req_d   = 1'b1;
               rw_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_CMP);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ar_q    <= '0;
         ac_q    <= '0;
         seed_q  <= '0;
         err_q   <= '0;
         qi_q    <= '0;
         req_q   <= 1'b0;
         rw_q    <= 1'b0;
         cs_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef MEMBIST_FAIL_CAPTURE_EN
         fail_seen_q <= 1'b0;
         fail_ar_q   <= '0;
         fail_ac_q   <= '0;
         fail_data_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ar_q    <= ar_d;
         ac_q    <= ac_d;
         seed_q  <= seed_d;
         err_q   <= err_d;
         qi_q    <= qi_d;
         req_q   <= req_d;
         rw_q    <= rw_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef MEMBIST_FAIL_CAPTURE_EN
         fail_seen_q <= fail_seen_d;
         fail_ar_q   <= fail_ar_d;
         fail_ac_q   <= fail_ac_d;
         fail_data_q <= fail_data_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_q;
   assign req     = req_q;
   assign rw      = rw_q;
   assign cs      = cs_q;
   assign Qi      = qi_q;
   assign ar      = ar_q;
   assign ac      = ac_q;
`ifdef MEMBIST_FAIL_CAPTURE_EN
   assign fail_ar   = fail_ar_q;
   assign fail_ac   = fail_ac_q;
   assign fail_data = fail_data_q;
`endif

endmodule
